// File: rtl/exception_sequencer_if.sv
// rtl/exception_sequencer_if.sv - exception sequencer signal bundle (status ports under EXC_STATUS_EN)
interface exception_sequencer_if;
   logic        exc_opcode_i;
   logic        exc_overflow_i;
   logic        exc_div0_i;
   logic [31:0] pc_i;
   logic [31:0] mem_data_i;
   logic [1:0]  excpt_ctrl_o;
   logic        mem_addr_sel_o;
   logic        mem_rd_o;
   logic [31:0] epc_o;
   logic [31:0] pc_o;
   logic        pc_wr_o;
   logic        busy_o;
`ifdef EXC_STATUS_EN
   logic [1:0]  cause_o;
   logic [0:0]  lost_o;
`endif

   // Environment side: raises requests, supplies PC and memory data
   modport master (
      output exc_opcode_i, exc_overflow_i, exc_div0_i, pc_i, mem_data_i,
      input  excpt_ctrl_o, mem_addr_sel_o, mem_rd_o, epc_o, pc_o, pc_wr_o, busy_o
`ifdef EXC_STATUS_EN
      , input cause_o, lost_o
`endif
   );

   // Sequencer side
   modport slave (
      input  exc_opcode_i, exc_overflow_i, exc_div0_i, pc_i, mem_data_i,
      output excpt_ctrl_o, mem_addr_sel_o, mem_rd_o, epc_o, pc_o, pc_wr_o, busy_o
`ifdef EXC_STATUS_EN
      , output cause_o, lost_o
`endif
   );
endinterface

// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - exception prioritiser, EPC save and vector fetch sequencer (optional EXC_STATUS_EN status ports)
module exception_sequencer #(
   parameter int unsigned MEM_LATENCY = 2,
   parameter logic [31:0] EPC_OFFSET  = 32'd4
) (
   input logic                   clk,
   input logic                   reset,
   exception_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      READ   = 3'd1,
      WAIT   = 3'd2,
      LOAD   = 3'd3,
      COMMIT = 3'd4
   } state_t;

   // Number of WAIT cycles between the read strobe and the data sample
   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [1:0]  ctrl_q;
   logic [31:0] epc_q;
   logic [31:0] pc_q;
   logic        mem_rd_q;
   logic        addr_sel_q;
   logic        pc_wr_q;
   logic        busy_q;
`ifdef EXC_STATUS_EN
   logic [1:0]  cause_q;
   logic        lost_q;
`endif

   logic        any_req;
   logic        multi_req;
   logic [1:0]  req_code;

   // Priority encode the raw requests: div0 > overflow > opcode
   always_comb begin
      any_req   = bus.exc_div0_i | bus.exc_overflow_i | bus.exc_opcode_i;
      multi_req = (bus.exc_div0_i & (bus.exc_overflow_i | bus.exc_opcode_i)) |
                  (bus.exc_overflow_i & bus.exc_opcode_i);
      req_code  = 2'b00;
      if (bus.exc_div0_i)
         req_code = 2'b10;
      else if (bus.exc_overflow_i)
         req_code = 2'b01;
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         ctrl_q     <= 2'b00;
         epc_q      <= 32'd0;
         pc_q       <= 32'd0;
         mem_rd_q   <= 1'b0;
         addr_sel_q <= 1'b0;
         pc_wr_q    <= 1'b0;
         busy_q     <= 1'b0;
`ifdef EXC_STATUS_EN
         cause_q    <= 2'b00;
         lost_q     <= 1'b0;
`endif
      end else begin
`ifdef EXC_STATUS_EN
         // Anything raised while a sequence runs is dropped; remember that
         if (busy_q && any_req)
            lost_q <= 1'b1;
`endif
         case (state_q)
            IDLE: begin
               mem_rd_q   <= 1'b0;
               pc_wr_q    <= 1'b0;
               addr_sel_q <= 1'b0;
               busy_q     <= 1'b0;
               if (any_req) begin
                  ctrl_q     <= req_code;
                  epc_q      <= bus.pc_i - EPC_OFFSET;
                  mem_rd_q   <= 1'b1;
                  addr_sel_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state_q    <= READ;
`ifdef EXC_STATUS_EN
                  cause_q    <= req_code;
                  if (multi_req)
                     lost_q <= 1'b1;
`endif
               end
            end
            READ: begin
               mem_rd_q <= 1'b0;
               cnt_q    <= LAT_M1;
               state_q  <= (MEM_LATENCY == 1) ? LOAD : WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q <= 4'd1)
                  state_q <= LOAD;
            end
            LOAD: begin
               // Vector table holds byte-wide handler addresses
               pc_q       <= {24'b0, bus.mem_data_i[7:0]};
               pc_wr_q    <= 1'b1;
               addr_sel_q <= 1'b0;
               state_q    <= COMMIT;
            end
            COMMIT: begin
               pc_wr_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               mem_rd_q   <= 1'b0;
               pc_wr_q    <= 1'b0;
               addr_sel_q <= 1'b0;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign bus.excpt_ctrl_o   = ctrl_q;
   assign bus.epc_o          = epc_q;
   assign bus.pc_o           = pc_q;
   assign bus.mem_rd_o       = mem_rd_q;
   assign bus.mem_addr_sel_o = addr_sel_q;
   assign bus.pc_wr_o        = pc_wr_q;
   assign bus.busy_o         = busy_q;
`ifdef EXC_STATUS_EN
   assign bus.cause_o        = cause_q;
   assign bus.lost_o         = lost_q;
`endif

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - self-checking bench for exception_sequencer
module tb_exception_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_div0, req_ov, req_op;
   logic [31:0] pc_in, mem_data;
   logic        sel_b;
   int          checks = 0;
   int          failures = 0;
   string       phase = "init";

   always #5 clk = ~clk;

   exception_sequencer_if ifa ();
   exception_sequencer_if ifb ();

   assign ifa.exc_div0_i     = req_div0;
   assign ifa.exc_overflow_i = req_ov;
   assign ifa.exc_opcode_i   = req_op;
   assign ifa.pc_i           = pc_in;
   assign ifa.mem_data_i     = mem_data;
   assign ifb.exc_div0_i     = req_div0;
   assign ifb.exc_overflow_i = req_ov;
   assign ifb.exc_opcode_i   = req_op;
   assign ifb.pc_i           = pc_in;
   assign ifb.mem_data_i     = mem_data;

   exception_sequencer #(.MEM_LATENCY(2), .EPC_OFFSET(32'd4)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   exception_sequencer #(.MEM_LATENCY(1), .EPC_OFFSET(32'd4)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   logic [1:0]  o_ctrl;
   logic [31:0] o_epc, o_pc;
   logic        o_rd, o_sel, o_wr, o_busy;
   assign o_ctrl = sel_b ? ifb.excpt_ctrl_o   : ifa.excpt_ctrl_o;
   assign o_epc  = sel_b ? ifb.epc_o          : ifa.epc_o;
   assign o_pc   = sel_b ? ifb.pc_o           : ifa.pc_o;
   assign o_rd   = sel_b ? ifb.mem_rd_o       : ifa.mem_rd_o;
   assign o_sel  = sel_b ? ifb.mem_addr_sel_o : ifa.mem_addr_sel_o;
   assign o_wr   = sel_b ? ifb.pc_wr_o        : ifa.pc_wr_o;
   assign o_busy = sel_b ? ifb.busy_o         : ifa.busy_o;

   typedef struct packed {
      logic [1:0]  ctrl;
      logic [31:0] epc;
      logic [31:0] pc;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s/%s observed=%h expected=%h", phase, tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From the LOAD cycle: expect pc_wr after exp_n edges, then compare against the scoreboard
   task automatic finish_seq(input int exp_n);
      int   n;
      exp_t e;
      n = 0;
      while (o_wr !== 1'b1 && n < 6) begin
         tick();
         n++;
      end
      chk("pc_wr_seen", {31'b0, o_wr}, 32'd1);
      chk("commit_cycle", n, exp_n);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("pc_o", o_pc, e.pc);
         chk("ctrl_commit", {30'b0, o_ctrl}, {30'b0, e.ctrl});
         chk("epc_commit", o_epc, e.epc);
      end else begin
         chk("sb_nonempty", 32'd0, 32'd1);
      end
      chk("sel_commit", {31'b0, o_sel}, 32'd0);
      chk("busy_commit", {31'b0, o_busy}, 32'd1);
      tick();
      chk("pc_wr_one_cycle", {31'b0, o_wr}, 32'd0);
      chk("busy_idle", {31'b0, o_busy}, 32'd0);
      chk("pc_hold", o_pc, e.pc);
   endtask

   // Accept one request at edge T and follow it to completion
   task automatic run_seq(input logic [2:0] req, input logic [31:0] pc, input logic [31:0] data,
                          input int lat, input logic [1:0] ectrl, input logic [31:0] eepc);
      logic [31:0] d;
      d = data;
      {req_div0, req_ov, req_op} = req;
      pc_in    = pc;
      mem_data = data;
      tick();
      {req_div0, req_ov, req_op} = 3'b000;
      chk("ctrl", {30'b0, o_ctrl}, {30'b0, ectrl});
      chk("epc", o_epc, eepc);
      chk("mem_rd", {31'b0, o_rd}, 32'd1);
      chk("busy", {31'b0, o_busy}, 32'd1);
      chk("sel", {31'b0, o_sel}, 32'd1);
      sb.push_back({ectrl, eepc, {24'b0, d[7:0]}});
      for (int i = 0; i < lat; i++) begin
         tick();
         chk("mem_rd_once", {31'b0, o_rd}, 32'd0);
         chk("sel_wait", {31'b0, o_sel}, 32'd1);
         chk("pc_wr_early", {31'b0, o_wr}, 32'd0);
      end
      finish_seq(1);
   endtask

   initial begin
      logic seen;
      reset = 1'b1;
      {req_div0, req_ov, req_op} = 3'b000;
      pc_in    = 32'd0;
      mem_data = 32'd0;
      sel_b    = 1'b0;
      repeat (3) tick();
      phase = "reset";
      chk("ctrl", {30'b0, o_ctrl}, 32'd0);
      chk("epc", o_epc, 32'd0);
      chk("pc", o_pc, 32'd0);
      chk("busy", {31'b0, o_busy}, 32'd0);
      chk("mem_rd", {31'b0, o_rd}, 32'd0);
      chk("pc_wr", {31'b0, o_wr}, 32'd0);
      chk("sel", {31'b0, o_sel}, 32'd0);
`ifdef EXC_STATUS_EN
      chk("lost", {31'b0, ifa.lost_o}, 32'd0);
`endif
      reset = 1'b0;
      tick();

      phase = "overflow";
      run_seq(3'b010, 32'h44, 32'hA0, 2, 2'b01, 32'h40);
      chk("ctrl_hold", {30'b0, o_ctrl}, 32'd1);
      chk("epc_hold", o_epc, 32'h40);
      chk("mem_rd_idle", {31'b0, o_rd}, 32'd0);
`ifdef EXC_STATUS_EN
      chk("lost", {31'b0, ifa.lost_o}, 32'd0);
      chk("cause", {30'b0, ifa.cause_o}, 32'd1);
`endif

      phase = "all3";
      run_seq(3'b111, 32'h10, 32'h12345678, 2, 2'b10, 32'h0C);
`ifdef EXC_STATUS_EN
      chk("lost", {31'b0, ifa.lost_o}, 32'd1);
      chk("cause", {30'b0, ifa.cause_o}, 32'd2);
`endif

      phase = "opcode";
      run_seq(3'b001, 32'h0, 32'hFFFFFF7C, 2, 2'b00, 32'hFFFFFFFC);

      phase = "busy_ignore";
      req_ov   = 1'b1;
      pc_in    = 32'h100;
      mem_data = 32'h11;
      tick();
      req_ov = 1'b0;
      chk("ctrl_first", {30'b0, o_ctrl}, 32'd1);
      sb.push_back({2'b01, 32'hFC, 32'h11});
      tick();
      req_div0 = 1'b1;
      chk("rd_t2", {31'b0, o_rd}, 32'd0);
      tick();
      chk("ctrl_t3", {30'b0, o_ctrl}, 32'd1);
      chk("rd_t3", {31'b0, o_rd}, 32'd0);
      finish_seq(1);
      chk("rd_t5", {31'b0, o_rd}, 32'd0);
      pc_in    = 32'h200;
      mem_data = 32'h22;
      tick();
      req_div0 = 1'b0;
      chk("rd_t6", {31'b0, o_rd}, 32'd1);
      chk("ctrl_t6", {30'b0, o_ctrl}, 32'd2);
      chk("epc_t6", o_epc, 32'h1FC);
      sb.push_back({2'b10, 32'h1FC, 32'h22});
      tick();
      tick();
      finish_seq(1);

      phase = "mid_reset";
      req_ov = 1'b1;
      pc_in  = 32'h300;
      tick();
      req_ov = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("busy", {31'b0, o_busy}, 32'd0);
      chk("mem_rd", {31'b0, o_rd}, 32'd0);
      chk("sel", {31'b0, o_sel}, 32'd0);
      chk("pc_wr", {31'b0, o_wr}, 32'd0);
      chk("ctrl", {30'b0, o_ctrl}, 32'd0);
      chk("epc", o_epc, 32'd0);
      chk("pc", o_pc, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen = seen | o_wr;
      end
      chk("no_pc_wr", {31'b0, seen}, 32'd0);
`ifdef EXC_STATUS_EN
      chk("lost_cleared", {31'b0, ifa.lost_o}, 32'd0);
`endif

      phase = "lat1";
      sel_b = 1'b1;
      tick();
      run_seq(3'b010, 32'h44, 32'h55, 1, 2'b01, 32'h40);

      phase = "end";
      chk("sb_empty", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/exception_sequencer.md
Name: exception_sequencer

Overview:
- Control-side companion to the exception vector mux.
- Takes raw exception requests and prioritises them. Encodes the 2-bit vector-select code and saves EPC.
- Drives a memory read of the vector byte at 253/254/255 and loads the handler address into PC.
- Sits between control unit, ALU/divider flags, memory address mux and PC register.

Parameters:
- MEM_LATENCY, 2, cycles from mem_rd_o assertion to valid mem_data_i; legal range 1..15.
- EPC_OFFSET, 4, value subtracted from pc_i to form EPC (pc_i is already incremented).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- exc_opcode_i  input  1  invalid-opcode request from control unit
- exc_overflow_i  input  1  ALU overflow request
- exc_div0_i  input  1  divide-by-zero request from divider
- pc_i  input  32  current PC value
- mem_data_i  input  32  memory read data
- excpt_ctrl_o  output  2  vector-select code to vector mux: 00 gives 253, 01 gives 254, 1x gives 255
- mem_addr_sel_o  output  1  selects vector mux output as memory address
- mem_rd_o  output  1  one-cycle memory read strobe
- epc_o  output  32  saved exception PC
- pc_o  output  32  handler target address
- pc_wr_o  output  1  one-cycle PC write enable
- busy_o  output  1  sequence in progress

Behaviour:
- Reset (synchronous, active-high) dominates everything. All outputs go to 0 and state returns to IDLE, including reset mid-sequence: any in-flight read is abandoned and no pc_wr_o is issued.
- IDLE:
  - Requests are sampled every cycle. If any is high at edge T, the sequencer accepts one.
  - Priority: div0 > overflow > opcode. excpt_ctrl_o <= 10 / 01 / 00 respectively.
  - epc_o <= pc_i - EPC_OFFSET, 32-bit modulo: pc_i = 0 gives 0xFFFFFFFC.
  - Next state is READ.
- READ (cycle T+1):
  - mem_rd_o = 1 for exactly this cycle.
  - mem_addr_sel_o = 1, busy_o = 1.
  - Wait counter loads MEM_LATENCY-1. Next state is WAIT, or LOAD directly when MEM_LATENCY = 1.
- WAIT:
  - mem_addr_sel_o and busy_o stay 1; counter decrements.
  - At 0 the next state is LOAD.
- LOAD (cycle T+1+MEM_LATENCY):
  - mem_data_i is sampled. pc_o <= {24'b0, mem_data_i[7:0]}.
  - mem_addr_sel_o = 1. Next state is COMMIT.
- COMMIT (cycle T+2+MEM_LATENCY):
  - pc_wr_o = 1 for this cycle only; pc_o is valid. busy_o = 1, mem_addr_sel_o = 0.
  - Next state is IDLE.
- Earliest new acceptance is the edge that ends the first IDLE cycle, at T+3+MEM_LATENCY.
- Requests arriving while busy_o = 1, including in COMMIT, are ignored. The producer must hold or re-raise them.
- Hold behaviour in IDLE:
  - excpt_ctrl_o, epc_o and pc_o hold their last values.
  - mem_rd_o, pc_wr_o, mem_addr_sel_o and busy_o are 0.
- Simultaneous requests: exactly one is accepted, per priority; the others are dropped.
- State encoding is one-hot or binary, implementer's choice; there are no illegal-state lockups (default returns to IDLE).

Optional Feature:
- Macro: EXC_STATUS_EN.
- Defined: adds outputs cause_o[1:0] and lost_o[0:0].
  - cause_o is the accepted code, latched with excpt_ctrl_o.
  - lost_o is a sticky 1 set when any request is high while busy_o = 1, or when a lower-priority request is dropped on simultaneous acceptance.
  - lost_o is cleared only by reset.
- Undefined: neither port exists and there is no extra logic.

Test Plan:
- MEM_LATENCY=2, pc_i=0x00000044, exc_overflow_i pulsed at T:
  - T+1: excpt_ctrl_o=01, epc_o=0x00000040, mem_rd_o=1.
  - mem_data_i=0x000000A0 at T+3.
  - T+4: pc_wr_o=1, pc_o=0x000000A0, for one cycle only.
- All three requests high together, pc_i=0x10:
  - excpt_ctrl_o=10, epc_o=0x0C.
  - With EXC_STATUS_EN: lost_o=1, cause_o=10.
- exc_opcode_i, pc_i=0:
  - excpt_ctrl_o=00, epc_o=0xFFFFFFFC.
  - mem_data_i=0xFFFFFF7C gives pc_o=0x0000007C (upper bits discarded).
- exc_div0_i raised at T+2, during WAIT:
  - Ignored: excpt_ctrl_o unchanged, no second mem_rd_o.
  - A new request at T+5 is accepted: mem_rd_o at T+6.
- reset asserted at T+2, mid-sequence:
  - T+3: all outputs 0, busy_o=0.
  - pc_wr_o never asserts.
- MEM_LATENCY=1 build:
  - mem_rd_o at T+1, LOAD at T+2, pc_wr_o at T+3.
